// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between the two UART requesters and uart_tx_arbiter.
interface uart_tx_arbiter_if;
  // valid/ready: a requester raises reqN_valid with reqN_data stable and holds both until it sees
  // reqN_ready high; that one-cycle pulse means the byte was taken on the previous clock edge.
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter for two byte requesters feeding one 8N1 serializer on the uart_tx pin.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between bit 7 and the stop bit).
module uart_tx_arbiter #(
  parameter int unsigned BAUD_DIV = 234
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus,
  output logic              uart_tx,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          last_grant;
  logic          any_valid;
  logic          grant;
  logic          accept;
  logic          bit_end;
  logic [7:0]    sel_data;
  logic          tx_d;
  logic          busy_d;
  logic          ready0_d;
  logic          ready1_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  // On contention the requester that did not win last time goes next; last_grant resets to 1.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign accept    = (state == S_IDLE) & any_valid;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign sel_data  = grant ? bus.req1_data : bus.req0_data;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_valid) state_next = S_START;
      S_START: if (bit_end)   state_next = S_DATA;
      S_DATA: begin
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_next = S_STOP;
`endif
      S_STOP:  if (bit_end)   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The baud counter wraps at every bit boundary, which is also every state entry after IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      last_grant <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;

      if (accept) begin
        shift      <= sel_data;
        bit_cnt    <= '0;
        last_grant <= grant;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^sel_data;
`endif
      end else if (state == S_DATA && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_bit;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d   = (state_next != S_IDLE);
    ready0_d = accept & ~grant;
    ready1_d = accept & grant;
  end

  // Registered outputs: the line trails the state by one clock, so tx falls two edges after valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_tx        <= 1'b1;
      busy           <= 1'b0;
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
    end else begin
      uart_tx        <= tx_d;
      busy           <= busy_d;
      bus.req0_ready <= ready0_d;
      bus.req1_ready <= ready1_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + light random bench for uart_tx_arbiter at BAUD_DIV=4 with a serial-line scoreboard.
// Define UART_TX_PARITY_EN here as well to check the 8E1 build.
module tb_uart_tx_arbiter;
  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * BAUD;
`else
  localparam int FRAME = 10 * BAUD;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_tx;
  logic       busy;
  logic [2:0] state_dbg;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.BAUD_DIV(BAUD)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         grant_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         frames_seen = 0;
  int         r0_cnt = 0;
  int         r1_cnt = 0;
`ifdef UART_TX_PARITY_EN
  logic       last_parity = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready pulses: record grant order and confirm the two readys never coincide.
  always @(negedge clk) begin
    if (!rst && (bus.req0_ready || bus.req1_ready)) begin
      check("ready_exclusive", bus.req0_ready & bus.req1_ready, 0);
      if (bus.req0_ready) begin r0_cnt++; grant_q.push_back(0); end
      if (bus.req1_ready) begin r1_cnt++; grant_q.push_back(1); end
    end
  end

  task automatic wait_bits(input int n, output logic aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) begin
        aborted = 1'b1;
        break;
      end
    end
  endtask

  // Serial receiver: sample mid-bit, rebuild the byte, compare with the queued expectation.
  task automatic mon_frame();
    logic [7:0] b;
    logic       ab;
    b = '0;
    wait_bits(BAUD / 2, ab);
    if (ab) return;
    check("start_bit", uart_tx, 0);
    for (int i = 0; i < 8; i++) begin
      wait_bits(BAUD, ab);
      if (ab) return;
      b[i] = uart_tx;
    end
`ifdef UART_TX_PARITY_EN
    wait_bits(BAUD, ab);
    if (ab) return;
    last_parity = uart_tx;
    check("parity_bit", uart_tx, ^b);
`endif
    wait_bits(BAUD, ab);
    if (ab) return;
    check("stop_bit", uart_tx, 1);
    frames_seen++;
    check("frame_queued", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check("frame_byte", b, exp_q.pop_front());
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) mon_frame();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drop_all();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop_all();
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  // Raise valid, hold until ready, drop valid; returns in the cycle the ready pulse is visible.
  task automatic send(input int who, input logic [7:0] d, input bit push_exp);
    int t;
    if (push_exp) exp_q.push_back(d);
    if (who == 0) begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    else          begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    t = 0;
    do begin
      step();
      t++;
    end while (!(who == 0 ? bus.req0_ready : bus.req1_ready) && t < 500);
    check("ready_seen", who == 0 ? bus.req0_ready : bus.req1_ready, 1);
    drop_all();
  endtask

  task automatic single(input int who, input logic [7:0] d, output int blen);
    send(who, d, 1'b1);
    check("busy_on_accept", busy, 1);
    check("line_high_on_accept", uart_tx, 1);
    step();
    check("start_bit_latency", uart_tx, 0);
    check("ready_one_cycle", who == 0 ? bus.req0_ready : bus.req1_ready, 0);
    blen = 2;
    while (busy && blen < 200) begin
      step();
      if (busy) blen++;
    end
    step(3);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 1000) begin
      step();
      t++;
    end
    check("idle_reached", busy, 0);
    step(3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         blen;
    int         base;
    int         fs;
    int         low;
    int         gap;
    int         bhi;
    int         exp_order[4];
    logic [7:0] rd_byte[2];
    int         rd_delay[2];
    logic [2:0] rd_state[2];
    exp_order = '{0, 1, 0, 1};
    rd_byte   = '{8'hFF, 8'h00};
    rd_delay  = '{17, 2};
    rd_state  = '{3'd2, 3'd1};

    bus.req0_data = '0;
    bus.req1_data = '0;
    drop_all();
    step(2);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    step(2);

    // single byte 0x55 from req0
    single(0, 8'h55, blen);
    check("busy_len_55", blen, FRAME);
    check("r0_count_55", r0_cnt, 1);
    check("frames_55", frames_seen, 1);

    // contention: both held, strict alternation starting with req0
    do_reset();
    grant_q.delete();
    base = r0_cnt + r1_cnt;
    fs = frames_seen;
    exp_q.push_back(8'hA0); exp_q.push_back(8'h0B);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h0B);
    bus.req0_data = 8'hA0; bus.req1_data = 8'h0B;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    blen = 0;
    while ((r0_cnt + r1_cnt - base) < 4 && blen < 5 * FRAME) begin
      step();
      blen++;
    end
    drop_all();
    wait_idle();
    check("contention_grants", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) check("grant_order", grant_q[i], exp_order[i]);
    check("contention_frames", frames_seen - fs, 4);

    // valid arriving while busy is held off, then starts one idle clock after the stop bit
    do_reset();
    send(0, 8'h11, 1'b1);
    step(10);
    exp_q.push_back(8'h3C);
    bus.req1_data = 8'h3C;
    bus.req1_valid = 1'b1;
    base = r1_cnt;
    blen = 0;
    while (busy && blen < 200) begin
      step();
      blen++;
    end
    check("no_ready_while_busy", r1_cnt - base, 0);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!busy && gap < 20);
    check("idle_gap_clocks", gap, 1);
    check("ready1_after_idle", bus.req1_ready, 1);
    check("line_high_in_gap", uart_tx, 1);
    drop_all();
    step();
    check("start_after_gap", uart_tx, 0);
    wait_idle();
    check("busy_ignore_queue", exp_q.size(), 0);

    // reset mid-frame: line high and busy low at once, no residual frame afterwards
    for (int k = 0; k < 2; k++) begin
      do_reset();
      fs = frames_seen;
      send(0, rd_byte[k], 1'b0);
      step(rd_delay[k]);
      check("state_before_reset", state_dbg, rd_state[k]);
      #1 rst = 1'b1;
      #1;
      check("midframe_rst_tx", uart_tx, 1);
      check("midframe_rst_busy", busy, 0);
      check("midframe_rst_state", state_dbg, 0);
      step(2);
      rst = 1'b0;
      low = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (uart_tx !== 1'b1 || busy !== 1'b0) low++;
      end
      check("no_residual_activity", low, 0);
      check("no_residual_frame", frames_seen - fs, 0);
    end

`ifdef UART_TX_PARITY_EN
    do_reset();
    single(0, 8'h07, blen);
    check("parity_07_value", last_parity, 1);
    check("parity_busy_len", blen, 44);
    single(1, 8'h03, blen);
    check("parity_03_value", last_parity, 0);
`endif

    // random bytes from random requesters with random idle gaps
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(0, 5));
      single($urandom_range(0, 1), 8'($urandom_range(0, 255)), blen);
      check("rand_busy_len", blen, FRAME);
    end

    // idle line for 1000 clocks
    do_reset();
    base = r0_cnt + r1_cnt;
    low = 0;
    bhi = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (uart_tx !== 1'b1) low++;
      if (busy !== 1'b0) bhi++;
    end
    check("idle_line_high", low, 0);
    check("idle_no_busy", bhi, 0);
    check("idle_no_ready", r0_cnt + r1_cnt - base, 0);

    step(5);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
